// File: rtl/iob_ila_dump_pkg.sv
// Shared definitions for the ILA dump initiator: FSM encoding, default ILA
// register map and the words-per-sample normalisation helper.
package iob_ila_dump_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_RD_SAMPLES = 3'd1;
  localparam state_t S_WR_INDEX   = 3'd2;
  localparam state_t S_WR_SEL     = 3'd3;
  localparam state_t S_RD_DATA    = 3'd4;
  localparam state_t S_PUSH       = 3'd5;
  localparam state_t S_DONE       = 3'd6;

  localparam int DEF_SAMPLES_ADDR = 0;
  localparam int DEF_INDEX_ADDR   = 1;
  localparam int DEF_SELECT_ADDR  = 2;
  localparam int DEF_DATA_ADDR    = 3;

  // A zero word count would never finish a sample, so it behaves as one.
  function automatic logic [7:0] eff_wps(input logic [7:0] wps);
    return (wps == 8'd0) ? 8'd1 : wps;
  endfunction

endpackage

// File: rtl/iob_ila_dump_xfer.sv
// Single native-bus transaction engine: launches one request, holds it until
// the responder accepts it, and leaves m_valid low for the cycle after.
module iob_ila_dump_xfer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                o_ack,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_m_valid,
  output logic [ADDR_W-1:0]   o_m_address,
  output logic [DATA_W-1:0]   o_m_wdata,
  output logic [DATA_W/8-1:0] o_m_wstrb,
  input  logic [DATA_W-1:0]   i_m_rdata,
  input  logic                i_m_ready
);

  logic                r_valid;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;

  // A new request is only taken while idle, so the acceptance cycle is always
  // followed by one cycle with m_valid low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_address <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (r_valid) begin
      if (i_m_ready) begin
        r_valid   <= 1'b0;
        r_address <= '0;
        r_wdata   <= '0;
        r_wstrb   <= '0;
      end
    end else if (i_req) begin
      r_valid   <= 1'b1;
      r_address <= i_addr;
      r_wdata   <= i_we ? i_wdata : '0;
      r_wstrb   <= i_we ? '1 : '0;
    end
  end

  assign o_ack       = r_valid & i_m_ready;
  assign o_rdata     = i_m_rdata;
  assign o_m_valid   = r_valid;
  assign o_m_address = r_address;
  assign o_m_wdata   = r_wdata;
  assign o_m_wstrb   = r_wstrb;

endmodule

// File: rtl/iob_ila_dump.sv
// ILA buffer drain engine: walks every sample/word through the ILA register
// interface and streams each DATA word out on a valid/ready port.
module iob_ila_dump
  import iob_ila_dump_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 32,
  parameter int BUFFER_W     = 10,
  parameter int SAMPLES_ADDR = DEF_SAMPLES_ADDR,
  parameter int INDEX_ADDR   = DEF_INDEX_ADDR,
  parameter int SELECT_ADDR  = DEF_SELECT_ADDR,
  parameter int DATA_ADDR    = DEF_DATA_ADDR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          words_per_sample,
  output logic                busy,
  output logic                done,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_valid,
  output logic                o_last,
  input  logic                o_ready
);

  localparam logic [DATA_W-1:0] MAX_N = {{(DATA_W-1){1'b0}}, 1'b1} << BUFFER_W;

  state_t              r_state, w_next;
  logic [BUFFER_W:0]   r_n, w_n_clamp;
  logic [BUFFER_W-1:0] r_i;
  logic [7:0]          r_w, r_wps;
  logic                r_abort, r_busy, r_done, r_o_valid, r_o_last;
  logic [DATA_W-1:0]   r_o_data;

  logic                w_req, w_we, w_ack, w_bus_state;
  logic                w_abort_now, w_abort_ok, w_capture;
  logic                w_last_word, w_last_idx;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata, w_rdata;

  assign w_n_clamp   = (w_rdata > MAX_N) ? MAX_N[BUFFER_W:0] : w_rdata[BUFFER_W:0];
  assign w_last_word = (r_w == r_wps - 8'd1);
  assign w_last_idx  = (({1'b0, r_i} + (BUFFER_W+1)'(1)) == r_n);
  assign w_bus_state = (r_state == S_RD_SAMPLES) || (r_state == S_WR_INDEX) ||
                       (r_state == S_WR_SEL) || (r_state == S_RD_DATA);
  // An abort may only leave a bus state once nothing is outstanding on the bus.
  assign w_abort_now = abort | r_abort;
  assign w_abort_ok  = w_abort_now & (w_ack | ~m_valid);
  assign w_capture   = (r_state == S_RD_DATA) & w_ack & ~w_abort_now;
  assign w_req       = (r_state == S_IDLE) ? start : (w_bus_state & ~w_abort_now);

  // Bus request attributes for the current state; IDLE pre-arms the SAMPLES read.
  always_comb begin
    w_we    = 1'b0;
    w_addr  = ADDR_W'(SAMPLES_ADDR);
    w_wdata = '0;
    case (r_state)
      S_WR_INDEX: begin
        w_we    = 1'b1;
        w_addr  = ADDR_W'(INDEX_ADDR);
        w_wdata = DATA_W'(r_i);
      end
      S_WR_SEL: begin
        w_we    = 1'b1;
        w_addr  = ADDR_W'(SELECT_ADDR);
        w_wdata = DATA_W'(r_w);
      end
      S_RD_DATA: begin
        w_we    = 1'b0;
        w_addr  = ADDR_W'(DATA_ADDR);
        w_wdata = '0;
      end
      default: begin
        w_we    = 1'b0;
        w_addr  = ADDR_W'(SAMPLES_ADDR);
        w_wdata = '0;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       w_next = start ? S_RD_SAMPLES : S_IDLE;
      S_RD_SAMPLES: begin
        if (w_abort_ok)  w_next = S_IDLE;
        else if (w_ack)  w_next = (w_n_clamp == '0) ? S_DONE : S_WR_INDEX;
        else             w_next = r_state;
      end
      S_WR_INDEX: begin
        if (w_abort_ok)  w_next = S_IDLE;
        else if (w_ack)  w_next = S_WR_SEL;
        else             w_next = r_state;
      end
      S_WR_SEL: begin
        if (w_abort_ok)  w_next = S_IDLE;
        else if (w_ack)  w_next = S_RD_DATA;
        else             w_next = r_state;
      end
      S_RD_DATA: begin
        if (w_abort_ok)  w_next = S_IDLE;
        else if (w_ack)  w_next = S_PUSH;
        else             w_next = r_state;
      end
      S_PUSH: begin
        if (abort)             w_next = S_IDLE;
        else if (!o_ready)     w_next = r_state;
        else if (!w_last_word) w_next = S_WR_SEL;
        else if (!w_last_idx)  w_next = S_WR_INDEX;
        else                   w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, status flags and the sticky abort request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (r_state == S_DONE);
      r_abort <= (r_state != S_IDLE) && (w_next != S_IDLE) && (r_abort || abort);
    end
  end

  // Sample count, sample index and word-select counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n   <= '0;
      r_i   <= '0;
      r_w   <= 8'd0;
      r_wps <= 8'd1;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_wps <= eff_wps(words_per_sample);
      end
      if ((r_state == S_RD_SAMPLES) && w_ack) begin
        r_n <= w_n_clamp;
        r_i <= '0;
        r_w <= 8'd0;
      end else if ((r_state == S_PUSH) && o_ready && !abort) begin
        if (!w_last_word) begin
          r_w <= r_w + 8'd1;
        end else if (!w_last_idx) begin
          r_i <= r_i + BUFFER_W'(1);
          r_w <= 8'd0;
        end
      end
    end
  end

  // Output stream register; o_data only changes when a new word is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;
      r_o_data  <= '0;
    end else if (w_capture) begin
      r_o_valid <= 1'b1;
      r_o_last  <= w_last_word & w_last_idx;
      r_o_data  <= w_rdata;
    end else if ((r_state == S_PUSH) && (o_ready || abort)) begin
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;
    end
  end

  iob_ila_dump_xfer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_xfer (
    .clk         (clk),
    .rst         (rst),
    .i_req       (w_req),
    .i_we        (w_we),
    .i_addr      (w_addr),
    .i_wdata     (w_wdata),
    .o_ack       (w_ack),
    .o_rdata     (w_rdata),
    .o_m_valid   (m_valid),
    .o_m_address (m_address),
    .o_m_wdata   (m_wdata),
    .o_m_wstrb   (m_wstrb),
    .i_m_rdata   (m_rdata),
    .i_m_ready   (m_ready)
  );

  assign busy    = r_busy;
  assign done    = r_done;
  assign o_valid = r_o_valid;
  assign o_last  = r_o_last;
  assign o_data  = r_o_data;

endmodule

// File: tb/tb_iob_ila_dump.sv
// Directed bench for iob_ila_dump: a behavioural ILA register responder, a
// stream/bus monitor and table-driven dumps plus multi-cycle corner sequences.
module tb_iob_ila_dump;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int BUFFER_W = 4;
  localparam logic [31:0] TAG = 32'hA500_0000;

  logic              clk, rst, start, abort;
  logic [7:0]        words_per_sample;
  logic              busy, done, m_valid, m_ready;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_wdata, m_rdata, o_data;
  logic [3:0]        m_wstrb;
  logic              o_valid, o_last, o_ready;

  iob_ila_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUFFER_W(BUFFER_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .words_per_sample(words_per_sample), .busy(busy), .done(done),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .o_ready(o_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Responder: ILA register file, answers after resp_delay extra cycles.
  logic [31:0] samples_val = 32'd0;
  logic [31:0] index_reg = 32'd0, select_reg = 32'd0;
  int resp_delay = 0, wait_cnt = 0, viol_strb = 0;

  initial begin
    m_ready = 1'b0;
    m_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst || m_ready) begin
        m_ready  = 1'b0;
        wait_cnt = 0;
      end else if (m_valid) begin
        if (wait_cnt >= resp_delay) begin
          m_ready = 1'b1;
          case (m_address)
            4'd0: m_rdata = samples_val;
            4'd1: index_reg = m_wdata;
            4'd2: select_reg = m_wdata;
            4'd3: m_rdata = TAG | (index_reg << 8) | select_reg;
            default: m_rdata = 32'd0;
          endcase
          if ((m_address == 4'd1) || (m_address == 4'd2)) begin
            if (m_wstrb != 4'hF) viol_strb++;
          end else if ((m_wstrb != 4'h0) || (m_wdata != 32'd0)) viol_strb++;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Monitor: samples just before each rising edge.
  logic [31:0] q_data[$];
  logic        q_last[$];
  int cyc = 0, done_cnt = 0, tx_cnt = 0, ov_cnt = 0, viol = 0, ready_cyc = 0, done_cyc = 0;
  logic p_valid = 1'b0, p_ready = 1'b0;
  logic [ADDR_W-1:0] p_addr = '0;
  logic [DATA_W-1:0] p_wdata = '0;

  initial begin
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (rst) begin
        p_valid = 1'b0;
        p_ready = 1'b0;
      end else begin
        if (o_valid && o_ready) begin
          q_data.push_back(o_data);
          q_last.push_back(o_last);
        end
        if (o_valid) ov_cnt++;
        if (o_last && !o_valid) viol++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (m_valid && m_ready) begin
          tx_cnt++;
          ready_cyc = cyc;
        end
        if (m_valid && o_valid) viol++;
        if (p_valid && !p_ready && !(m_valid && (m_address == p_addr) && (m_wdata == p_wdata))) viol++;
        if (p_valid && p_ready && m_valid) viol++;
        p_valid = m_valid;
        p_ready = m_ready;
        p_addr  = m_address;
        p_wdata = m_wdata;
      end
    end
  end

  task automatic start_dump(input logic [31:0] n, input logic [7:0] wps);
    samples_val = n;
    words_per_sample = wps;
    q_data.delete();
    q_last.delete();
    done_cnt = 0;
    tx_cnt = 0;
    ov_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_mvalid", m_valid, 1);
    chk("start_addr", m_address, 0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_stream(input int n_eff, input int wps_eff);
    int nw;
    logic [31:0] exp;
    nw = n_eff * wps_eff;
    chk("word_count", q_data.size(), nw);
    if (q_data.size() == nw) begin
      for (int k = 0; k < nw; k++) begin
        exp = TAG | (32'(k / wps_eff) << 8) | 32'(k % wps_eff);
        chk("word_data", q_data[k], exp);
        chk("word_last", q_last[k], (k == nw - 1) ? 1 : 0);
      end
    end
  endtask

  typedef struct {
    logic [31:0] samples;
    logic [7:0]  wps;
    int          n_eff;
    int          wps_eff;
    int          exp_tx;
    int          exp_gap;
  } vec_t;

  vec_t vecs[6];
  logic [31:0] held;
  int stall_left;
  logic found;

  initial begin
    vecs[0] = '{32'd3,  8'd2, 3,  2, 16, 3};
    vecs[1] = '{32'd0,  8'd2, 0,  2, 1,  2};
    vecs[2] = '{32'd40, 8'd1, 16, 1, 49, 3};
    vecs[3] = '{32'd2,  8'd0, 2,  1, 7,  3};
    vecs[4] = '{32'd1,  8'd3, 1,  3, 8,  3};
    vecs[5] = '{32'd17, 8'd1, 16, 1, 49, 3};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    o_ready = 1'b1;
    words_per_sample = 8'd1;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {busy, done, m_valid, o_valid, o_last}, 0);
    chk("reset_bus", {m_address, m_wstrb, m_wdata}, 0);
    chk("reset_odata", o_data, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      start_dump(vecs[v].samples, vecs[v].wps);
      wait_idle();
      check_stream(vecs[v].n_eff, vecs[v].wps_eff);
      chk("done_pulses", done_cnt, 1);
      chk("bus_tx", tx_cnt, vecs[v].exp_tx);
      chk("done_gap", done_cyc - ready_cyc, vecs[v].exp_gap);
    end

    // Backpressure on the second word.
    stall_left = 5;
    held = 32'd0;
    start_dump(32'd3, 8'd2);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy) break;
      if (stall_left > 0 && o_valid && q_data.size() == 1) begin
        if (stall_left == 5) held = o_data;
        else chk("bp_stable", o_data, held);
        chk("bp_mvalid", m_valid, 0);
        o_ready = 1'b0;
        stall_left--;
      end else begin
        o_ready = 1'b1;
      end
    end
    o_ready = 1'b1;
    chk("bp_busy", busy, 0);
    chk("bp_stalled", stall_left, 0);
    chk("bp_held", held, TAG | 32'h0000_0001);
    repeat (3) @(negedge clk);
    check_stream(3, 2);
    chk("bp_done", done_cnt, 1);

    // Abort while the first DATA read is stalled by the responder.
    resp_delay = 4;
    start_dump(32'd3, 8'd2);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (m_valid && m_address == 4'd3) found = 1'b1;
    end
    chk("abort_reach", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_hold", m_valid, 1);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("abort_nodone", done_cnt, 0);
    chk("abort_novalid", ov_cnt, 0);
    chk("abort_tx", tx_cnt, 4);
    chk("abort_idle", m_valid, 0);
    resp_delay = 0;

    // Reset while a word is waiting in PUSH, then a clean restart.
    o_ready = 1'b0;
    start_dump(32'd3, 8'd2);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (o_valid) found = 1'b1;
    end
    chk("rst_reach", found, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_ctl", {busy, done, m_valid, o_valid, o_last}, 0);
    chk("rst_async_bus", {m_address, m_wstrb, m_wdata}, 0);
    chk("rst_async_odata", o_data, 0);
    @(negedge clk);
    rst = 1'b0;
    o_ready = 1'b1;
    @(negedge clk);
    start_dump(32'd3, 8'd2);
    wait_idle();
    check_stream(3, 2);
    chk("restart_done", done_cnt, 1);
    chk("restart_tx", tx_cnt, 16);

    chk("bus_protocol", viol, 0);
    chk("write_strobe", viol_strb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
